// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard detection and forwarding control for a five-stage pipeline with a
//   multi-cycle multiply/divide unit (MDU).
//
//   - EX operand forwarding (forwardAE/forwardBE): MEM result over WB result
//     over register file.
//   - ID branch-comparator forwarding (forwardAD/forwardBD) from MEM.
//   - Load-use stall, branch-operand stall and MDU busy stall, merged into
//     stallF/stallD with zero-cycle latency.
//   - Flush control: flushE follows stallD so a bubble is inserted into EX.
//     flushD is taken only when no stall is active, so a redirect that arrives
//     during a stall is held off until the stall clears.
//   - A two-state MDU FSM (IDLE/BUSY) with an 8-bit down-counter keeps mduBusy
//     high for MDU_LATENCY cycles after an accepted mduStartE.
//
// Parameters
//   MDU_LATENCY   stall cycles per MDU operation, 1..255 (default 32)
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   rsD, rtD                       ID-stage source registers
//   rsE, rtE                       EX-stage source registers
//   writeRegE/Regfile_weE/memToRegE  EX destination, write enable, load flag
//   writeRegM/Regfile_weM/memToRegM  MEM destination, write enable, load flag
//   writeRegW/Regfile_weW          WB destination, write enable
//   branchD, pcSrcD                branch in ID, redirect taken
//   mduStartE                      MDU operation issues from EX
//   stallF, stallD                 hold PC and IF/ID
//   flushD, flushE                 clear IF/ID and ID/EX
//   forwardAE, forwardBE           EX operand select (00 RF, 01 WB, 10 MEM)
//   forwardAD, forwardBD           ID comparator operand takes MEM result
//   mduBusy                        MDU FSM is in BUSY
//
// Optional feature (macro HAZARD_PERF_CNT_EN)
//   stallCnt[31:0]   cycles with stallD=1, saturating
//   flushCnt[31:0]   cycles with flushD|flushE=1, saturating
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic       Regfile_weE,
  input  logic       memToRegE,
  input  logic [4:0] writeRegM,
  input  logic       Regfile_weM,
  input  logic       memToRegM,
  input  logic [4:0] writeRegW,
  input  logic       Regfile_weW,
  input  logic       branchD,
  input  logic       pcSrcD,
  input  logic       mduStartE,
  output logic       stallF,
  output logic       stallD,
  output logic       flushD,
  output logic       flushE,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic       mduBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stallCnt,
  output logic [31:0] flushCnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // Counter load value: BUSY lasts cnt+1 cycles, so MDU_LATENCY-1 gives
  // exactly MDU_LATENCY busy cycles.
  localparam logic [7:0] CNT_LOAD = 8'(MDU_LATENCY - 1);

  mdu_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic lwstall;
  logic branchstall;
  logic stall;

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] ex_fwd_sel(input logic [4:0] src);
    if (Regfile_weM && (writeRegM != 5'd0) && (writeRegM == src)) begin
      return 2'b10;
    end else if (Regfile_weW && (writeRegW != 5'd0) && (writeRegW == src)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  assign forwardAE = ex_fwd_sel(rsE);
  assign forwardBE = ex_fwd_sel(rtE);

  assign forwardAD = Regfile_weM && (writeRegM != 5'd0) && (writeRegM == rsD);
  assign forwardBD = Regfile_weM && (writeRegM != 5'd0) && (writeRegM == rtD);

  // ---------------------------------------------------------------------------
  // Stall detection
  // ---------------------------------------------------------------------------
  assign lwstall = memToRegE && (writeRegE != 5'd0) &&
                   ((writeRegE == rsD) || (writeRegE == rtD));

  // The branch comparator in ID needs its operands now: an EX-stage producer
  // cannot be forwarded yet, and a MEM-stage load has no data until WB.
  assign branchstall = branchD &&
    ((Regfile_weE && (writeRegE != 5'd0) &&
      ((writeRegE == rsD) || (writeRegE == rtD))) ||
     (memToRegM && (writeRegM != 5'd0) &&
      ((writeRegM == rsD) || (writeRegM == rtD))));

  assign mduBusy = (state_q == BUSY);
  assign stall   = lwstall | branchstall | mduBusy;

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;
  assign flushD = pcSrcD && !stall;

  // ---------------------------------------------------------------------------
  // MDU FSM
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (mduStartE) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        // Starts arriving while BUSY, including on the last BUSY cycle, are
        // dropped: the EX stage is stalled and will reissue.
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so all
  // registers sample their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stallD && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((flushD || flushE) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed-vector bench for hazard_ctrl with MDU_LATENCY=4. Inputs are driven
//   1 time unit after the rising edge; outputs are sampled 1 unit after that.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] writeRegE, writeRegM, writeRegW;
  logic       Regfile_weE, memToRegE;
  logic       Regfile_weM, memToRegM;
  logic       Regfile_weW;
  logic       branchD, pcSrcD, mduStartE;
  logic       stallF, stallD, flushD, flushE;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD;
  logic       mduBusy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  hazard_ctrl #(.MDU_LATENCY(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rsD         (rsD),
    .rtD         (rtD),
    .rsE         (rsE),
    .rtE         (rtE),
    .writeRegE   (writeRegE),
    .Regfile_weE (Regfile_weE),
    .memToRegE   (memToRegE),
    .writeRegM   (writeRegM),
    .Regfile_weM (Regfile_weM),
    .memToRegM   (memToRegM),
    .writeRegW   (writeRegW),
    .Regfile_weW (Regfile_weW),
    .branchD     (branchD),
    .pcSrcD      (pcSrcD),
    .mduStartE   (mduStartE),
    .stallF      (stallF),
    .stallD      (stallD),
    .flushD      (flushD),
    .flushE      (flushE),
    .forwardAE   (forwardAE),
    .forwardBE   (forwardBE),
    .forwardAD   (forwardAD),
    .forwardBD   (forwardBD),
    .mduBusy     (mduBusy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stallCnt    (stallCnt),
    .flushCnt    (flushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the directed sequence is fixed-length, this only guards a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeRegE = '0; Regfile_weE = 1'b0; memToRegE = 1'b0;
    writeRegM = '0; Regfile_weM = 1'b0; memToRegM = 1'b0;
    writeRegW = '0; Regfile_weW = 1'b0;
    branchD = 1'b0; pcSrcD = 1'b0; mduStartE = 1'b0;
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the stall/flush group at once.
  task automatic check_stall(input string tag, input logic s, input logic fd);
    check({tag, "_stallF"}, 32'(stallF), 32'(s));
    check({tag, "_stallD"}, 32'(stallD), 32'(s));
    check({tag, "_flushE"}, 32'(flushE), 32'(s));
    check({tag, "_flushD"}, 32'(flushD), 32'(fd));
  endtask

  task automatic pulse_reset();
    step();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Expected mduBusy per cycle after the start edge, and start pattern.
  logic busy_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic start_pat[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    clear_inputs();
    rst = 1'b1;

    // ---------------- reset state ----------------
    #3;
    check("rst_busy",  32'(mduBusy),   0);
    check_stall("rst", 1'b0, 1'b0);
    check("rst_fwdAE", 32'(forwardAE), 0);
    check("rst_fwdBE", 32'(forwardBE), 0);
    check("rst_fwdAD", 32'(forwardAD), 0);
    check("rst_fwdBD", 32'(forwardBD), 0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_stallCnt", stallCnt, 0);
    check("rst_flushCnt", flushCnt, 0);
`endif
    step();
    rst = 1'b0;

    // ---------------- EX forwarding ----------------
    writeRegM = 5'd5; Regfile_weM = 1'b1;
    writeRegW = 5'd5; Regfile_weW = 1'b1;
    rsE = 5'd5;
    #1 check("fwdAE_mem_over_wb", 32'(forwardAE), 2);
    check("fwdBE_nomatch", 32'(forwardBE), 0);
    Regfile_weM = 1'b0;
    #1 check("fwdAE_wb", 32'(forwardAE), 1);
    writeRegM = 5'd0; writeRegW = 5'd0; Regfile_weM = 1'b1;
    #1 check("fwdAE_r0", 32'(forwardAE), 0);
    rtE = 5'd9; writeRegW = 5'd9;
    #1 check("fwdBE_wb", 32'(forwardBE), 1);
    writeRegM = 5'd9;
    #1 check("fwdBE_mem", 32'(forwardBE), 2);
    check("fwd_no_stall", 32'(stallD), 0);

    // ---------------- ID forwarding ----------------
    clear_inputs();
    writeRegM = 5'd4; Regfile_weM = 1'b1; rsD = 5'd4; rtD = 5'd3;
    #1 check("fwdAD_hit", 32'(forwardAD), 1);
    check("fwdBD_miss", 32'(forwardBD), 0);
    rtD = 5'd4; Regfile_weM = 1'b0;
    #1 check("fwdBD_we0", 32'(forwardBD), 0);
    Regfile_weM = 1'b1;
    #1 check("fwdBD_hit", 32'(forwardBD), 1);

    // ---------------- load-use stall ----------------
    clear_inputs();
    memToRegE = 1'b1; writeRegE = 5'd8; rtD = 5'd8;
    #1 check_stall("lw", 1'b1, 1'b0);
    pcSrcD = 1'b1;
    #1 check("lw_redirect_held", 32'(flushD), 0);
    pcSrcD = 1'b0; writeRegE = 5'd0; rtD = 5'd0;
    #1 check_stall("lw_r0", 1'b0, 1'b0);

    // ---------------- branch stalls ----------------
    clear_inputs();
    branchD = 1'b1; Regfile_weE = 1'b1; writeRegE = 5'd3; rsD = 5'd3;
    #1 check("br_ex", 32'(stallD), 1);
    branchD = 1'b0;
    #1 check("br_ex_nobranch", 32'(stallD), 0);
    clear_inputs();
    branchD = 1'b1; memToRegM = 1'b1; writeRegM = 5'd6; rtD = 5'd6;
    #1 check("br_memload", 32'(stallD), 1);
    memToRegM = 1'b0;
    #1 check("br_mem_notload", 32'(stallD), 0);
    clear_inputs();

    // ---------------- MDU: 4 busy cycles, later starts ignored ----------------
    step();
    mduStartE = 1'b1;
    #1 check("mdu_start_cycle", 32'(mduBusy), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      mduStartE = start_pat[i];
      #1;
      check($sformatf("mdu_busy_c%0d", i + 1), 32'(mduBusy), 32'(busy_exp[i]));
      check($sformatf("mdu_stall_c%0d", i + 1), 32'(stallF), 32'(busy_exp[i]));
    end
    mduStartE = 1'b0;

    // ---------------- async reset mid-BUSY ----------------
    step();
    mduStartE = 1'b1;
    step();
    mduStartE = 1'b0;
    check("mdu2_busy_c1", 32'(mduBusy), 1);
    step();
    check("mdu2_busy_c2", 32'(mduBusy), 1);
    #2 rst = 1'b1;
    #1 check("async_rst_busy", 32'(mduBusy), 0);
    check("async_rst_stall", 32'(stallF), 0);
    #1 rst = 1'b0;
    mduStartE = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      mduStartE = 1'b0;
      check($sformatf("mdu3_busy_c%0d", i + 1), 32'(mduBusy), 32'(busy_exp[i]));
    end

    // ---------------- redirect deferred by a branch stall ----------------
    pulse_reset();
    step();
    branchD = 1'b1; Regfile_weE = 1'b1; writeRegE = 5'd7; rsD = 5'd7;
    pcSrcD = 1'b1;
    #1 check_stall("redir_c1", 1'b1, 1'b0);
    step();
    branchD = 1'b0; Regfile_weE = 1'b0; writeRegE = 5'd0; rsD = 5'd0;
    #1 check_stall("redir_c2", 1'b0, 1'b1);
    step();
    pcSrcD = 1'b0;
    #1 check_stall("redir_c3", 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stallCnt", stallCnt, 1);
    check("perf_flushCnt", flushCnt, 2);
    step();
    check("perf_stallCnt_hold", stallCnt, 1);
    check("perf_flushCnt_hold", flushCnt, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
